// File: rtl/mac_ctrl_pkg.sv
// Shared widths, state encoding and helpers for the 3x3 MAC window controller.
// The width macros are defined here once so every file of the slice sees the
// same values; the package mirrors them as typed localparams.

`ifndef MAC_CTRL_WIDTHS
`define MAC_CTRL_WIDTHS
`define WID_FILTER  8
`define WID_MAC_OUT 20
`endif

package mac_ctrl_pkg;

   // Signed weight width and signed MAC result width (9 products of 8x8 bits).
   localparam int FILTER_W  = `WID_FILTER;
   localparam int MAC_OUT_W = `WID_MAC_OUT;

   // Number of filter taps and width of the weight index.
   localparam int NUM_TAPS = 9;
   localparam int ADDR_W   = 4;

   // Controller FSM states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // True when a weight index names one of the nine real taps.
   function automatic logic isTapAddr(input logic [ADDR_W-1:0] addr);
      return addr < ADDR_W'(NUM_TAPS);
   endfunction

endpackage

// File: rtl/mac_ctrl_if.sv
// Bus bundle between the parent (window source, attached MAC, result sink)
// and the MAC controller. The master side is the parent, the slave side is
// the controller.

interface mac_ctrl_if
   import mac_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) ();

   // Weight configuration port.
   logic                        cfg_we;
   logic        [ADDR_W-1:0]    cfg_addr;
   logic signed [FILTER_W-1:0]  cfg_data;

   // Pass control.
   logic                        start;
   logic        [CNT_W-1:0]     num_windows;
   logic                        busy;
   logic                        done;

   // Window stream handshake.
   logic                        win_valid;
   logic                        win_ready;

   // Attached MAC: weights out, enable out, result back in.
   logic signed [FILTER_W-1:0]  filter_1;
   logic signed [FILTER_W-1:0]  filter_2;
   logic signed [FILTER_W-1:0]  filter_3;
   logic signed [FILTER_W-1:0]  filter_4;
   logic signed [FILTER_W-1:0]  filter_5;
   logic signed [FILTER_W-1:0]  filter_6;
   logic signed [FILTER_W-1:0]  filter_7;
   logic signed [FILTER_W-1:0]  filter_8;
   logic signed [FILTER_W-1:0]  filter_9;
   logic                        mac_enable;
   logic signed [MAC_OUT_W-1:0] mac_result;

   // Result stream.
   logic                        out_valid;
   logic signed [MAC_OUT_W-1:0] out_data;

   modport master (
      output cfg_we, cfg_addr, cfg_data, start, num_windows, win_valid, mac_result,
      input  win_ready, busy, done, mac_enable, out_valid, out_data,
      input  filter_1, filter_2, filter_3, filter_4, filter_5,
      input  filter_6, filter_7, filter_8, filter_9
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_data, start, num_windows, win_valid, mac_result,
      output win_ready, busy, done, mac_enable, out_valid, out_data,
      output filter_1, filter_2, filter_3, filter_4, filter_5,
      output filter_6, filter_7, filter_8, filter_9
   );

endinterface

// File: rtl/mac_ctrl.sv
// Controller for an externally instantiated 3x3 MAC. It holds the nine
// weights, accepts num_windows windows per pass, tracks each accepted window
// through a MAC_LAT-deep valid pipe to time mac_enable and out_valid, and
// pulses done once the last result has left the pipe.

module mac_ctrl
   import mac_ctrl_pkg::*;
#(
   parameter int MAC_LAT = 3,
   parameter int CNT_W   = 16
) (
   input  logic     clk,
   input  logic     rst,
   mac_ctrl_if.slave bus
);

   // Marks the oldest pipe slot; it is the one presenting out_valid.
   localparam logic [MAC_LAT-1:0] TOP_SLOT = MAC_LAT'(1) << (MAC_LAT - 1);

   state_t                      state;
   state_t                      stateNext;
   logic        [CNT_W-1:0]     winCount;
   logic        [CNT_W-1:0]     numLatched;
   logic        [MAC_LAT-1:0]   validPipe;
   logic        [MAC_LAT:0]     slotValid;
   logic signed [FILTER_W-1:0]  weights [NUM_TAPS];
   logic                        zeroDone;
   logic                        accept;
   logic                        startAccept;
   logic                        lastAccept;
   logic                        weightWrite;
   logic                        winReady;
   logic                        busyOut;
   logic                        doneOut;

   assign accept      = bus.win_valid && (state == RUN);
   assign startAccept = bus.start && (state == IDLE);
   assign lastAccept  = accept && ((winCount + CNT_W'(1)) == numLatched);
   assign weightWrite = bus.cfg_we && (state == IDLE) && isTapAddr(bus.cfg_addr);

   // slotValid[k] is set when a window was accepted k cycles ago.
   assign slotValid = {validPipe, accept};

   assign bus.mac_enable = slotValid[MAC_LAT-1];
   assign bus.out_valid  = slotValid[MAC_LAT];
   assign bus.out_data   = slotValid[MAC_LAT] ? bus.mac_result : '0;
   assign bus.win_ready  = winReady;
   assign bus.busy       = busyOut;
   assign bus.done       = doneOut;

   assign bus.filter_1 = weights[0];
   assign bus.filter_2 = weights[1];
   assign bus.filter_3 = weights[2];
   assign bus.filter_4 = weights[3];
   assign bus.filter_5 = weights[4];
   assign bus.filter_6 = weights[5];
   assign bus.filter_7 = weights[6];
   assign bus.filter_8 = weights[7];
   assign bus.filter_9 = weights[8];

   // State register, window counter, valid pipe and the zero-length done flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         winCount   <= '0;
         numLatched <= '0;
         validPipe  <= '0;
         zeroDone   <= 1'b0;
      end else begin
         state     <= stateNext;
         validPipe <= slotValid[MAC_LAT-1:0];
         zeroDone  <= startAccept && (bus.num_windows == '0);
         if (startAccept) begin
            winCount   <= '0;
            numLatched <= bus.num_windows;
         end else if (accept) begin
            winCount <= winCount + CNT_W'(1);
         end
      end
   end

   // Weight registers; only written while idle so a pass sees stable weights.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_TAPS; i++) begin
            weights[i] <= '0;
         end
      end else if (weightWrite) begin
         for (int i = 0; i < NUM_TAPS; i++) begin
            if (bus.cfg_addr == ADDR_W'(i)) begin
               weights[i] <= bus.cfg_data;
            end
         end
      end
   end

   // Next-state and handshake/status outputs; DRAIN leaves when only the
   // result now on out_valid remains, so done follows the last result directly.
   always_comb begin
      stateNext = state;
      winReady  = 1'b0;
      busyOut   = (state != IDLE);
      doneOut   = zeroDone;
      case (state)
         IDLE: begin
            if (bus.start && (bus.num_windows != '0)) begin
               stateNext = RUN;
            end
         end
         RUN: begin
            winReady = 1'b1;
            if (lastAccept) begin
               stateNext = DRAIN;
            end
         end
         DRAIN: begin
            if ((validPipe & ~TOP_SLOT) == '0) begin
               stateNext = DONE;
            end
         end
         DONE: begin
            doneOut   = 1'b1;
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

endmodule

// File: doc/mac_ctrl.md
MAC_CTRL -- requirements
Module: mac_ctrl

Interface
REQ-001 Parameter MAC_LAT, default 3, accept-to-result latency of the attached 3x3 MAC in cycles.
REQ-002 Parameter CNT_W, default 16, width of the window counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cfg_we  input  1  filter weight write strobe.
REQ-006 cfg_addr  input  4  weight index 0..8.
REQ-007 cfg_data  input  `WID_FILTER  signed weight value.
REQ-008 start  input  1  begin a pass of num_windows windows.
REQ-009 num_windows  input  CNT_W  window count, sampled on accepted start.
REQ-010 win_valid  input  1  upstream 3x3 window present on the MAC line inputs.
REQ-011 win_ready  output  1  controller accepts a window this cycle.
REQ-012 filter_1..filter_9  output  `WID_FILTER each  registered weights driven to the MAC filter inputs.
REQ-013 mac_enable  output  1  drives the MAC enable.
REQ-014 mac_result  input  `WID_MAC_OUT  MAC output.
REQ-015 out_valid  output  1  out_data holds one window result.
REQ-016 out_data  output  `WID_MAC_OUT  signed result.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 done  output  1  single-cycle pulse at pass end.

Function
REQ-019 The FSM SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-020 IDLE->RUN on start with num_windows!=0; on start with num_windows==0 the controller SHALL pulse done in the next cycle and remain in IDLE.
REQ-021 In RUN, win_ready SHALL be 1; an accept is win_valid&win_ready; win_ready SHALL be 0 in every other state.
REQ-022 The accepted-window counter SHALL increment per accept; the accept that reaches num_windows SHALL move RUN->DRAIN.
REQ-023 DRAIN->DONE once the latency pipeline holds no valid bits; DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-024 A MAC_LAT-deep valid shift register SHALL track accepts: accept in cycle t gives mac_enable=1 in cycle t+MAC_LAT-1 and out_valid=1 in cycle t+MAC_LAT.
REQ-025 mac_enable SHALL be 0 whenever no accepted window occupies that pipeline slot.
REQ-026 out_data SHALL equal mac_result when out_valid=1, else 0.
REQ-027 Back-to-back accepts SHALL give back-to-back out_valid, with no bubbles and no window lost or duplicated.
REQ-028 cfg_we with cfg_addr 0..8 SHALL write filter_(addr+1) only in IDLE; writes while busy, or to addr 9..15, SHALL be ignored.
REQ-029 A write and start in the same IDLE cycle SHALL apply the write before the pass begins.
REQ-030 start while busy SHALL be ignored; num_windows SHALL be latched only on an accepted start.
REQ-031 Counter width SHALL be CNT_W; num_windows = 2^CNT_W-1 SHALL complete without wrap.

Reset
REQ-032 rst SHALL set state=IDLE, counter=0, valid pipe=0, filter_1..9=0, win_ready=0, mac_enable=0, out_valid=0, out_data=0, busy=0, done=0.
REQ-033 rst mid-pass SHALL abort: no further out_valid and no done pulse from the aborted pass.

Structure
REQ-034 `WID_FILTER, `WID_MAC_OUT and the FSM state encodings SHALL live in header.vh.
REQ-035 No sub-module is needed; the MAC is instantiated beside mac_ctrl by the parent, not inside it.

Verification
REQ-036 Weights all 1, start with num_windows=4, four consecutive windows of all 2s -> out_valid high in four consecutive cycles starting 3 cycles after the first accept, each out_data=18, then done one cycle later.
REQ-037 num_windows=3 with win_valid toggling 1,0,1,0,1 -> three results each exactly 3 cycles after its accept, mac_enable high only in the matching cycles.
REQ-038 cfg write addr 4 value -5 while busy, then in IDLE -> filter_5 unchanged while busy, -5 after the IDLE write; write to addr 12 -> no change.
REQ-039 start with num_windows=0 -> done pulse next cycle, busy stays 0, win_ready stays 0.
REQ-040 rst asserted after 2 of 5 windows accepted -> all outputs 0 next cycle, no done; a new pass of 2 windows then completes normally.
REQ-041 Weights 1..9 with windows all -1 -> out_data=-45, sign preserved.
